// File: rtl/wfg_record_pat.sv
// rtl/wfg_record_pat.sv - pattern recorder: sync-triggered pin capture into an AXI-Stream FIFO
module wfg_record_pat #(
  parameter int CHANNELS        = 32,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       ctrl_en_i,
  input  logic [7:0]                 cfg_subcycle_i,
  input  logic [CHANNELS-1:0]        cfg_mask_i,
  input  logic [15:0]                cfg_frame_len_i,
  input  logic                       clr_overflow_i,
  input  logic                       wfg_pat_sync_i,
  input  logic [7:0]                 wfg_pat_subcycle_cnt_i,
  input  logic [CHANNELS-1:0]        pat_din_i,
  input  logic                       wfg_axis_tready_i,
  output logic                       wfg_axis_tvalid_o,
  output logic                       wfg_axis_tlast_o,
  output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
  output logic                       overflow_o,
  output logic                       active_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [CHANNELS-1:0]        din_meta;
  logic [CHANNELS-1:0]        din_s;
  logic [CHANNELS-1:0]        masked;
  logic [AXIS_DATA_WIDTH-1:0] sample_word;

  logic [AXIS_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic                       mem_last [FIFO_DEPTH];
  logic [AW:0]                wr_ptr;
  logic [AW:0]                rd_ptr;
  logic [15:0]                frame_cnt;

  logic sample_event;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;
  logic frame_last;

  // Two-flop synchronizer for the asynchronous pad inputs
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      din_meta <= '0;
      din_s    <= '0;
    end else begin
      din_meta <= pat_din_i;
      din_s    <= din_meta;
    end
  end

  assign masked = din_s & cfg_mask_i;

  // Fit the masked sample onto the stream width: zero-extend or keep the LSBs
  generate
    if (CHANNELS >= AXIS_DATA_WIDTH) begin : g_trunc
      assign sample_word = masked[AXIS_DATA_WIDTH-1:0];
    end else begin : g_ext
      assign sample_word = {{(AXIS_DATA_WIDTH-CHANNELS){1'b0}}, masked};
    end
  endgenerate

  assign sample_event = ctrl_en_i & wfg_pat_sync_i &
                        (wfg_pat_subcycle_cnt_i == cfg_subcycle_i);

  // The extra pointer bit separates full (MSBs differ) from empty (equal)
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop  = !fifo_empty && wfg_axis_tready_i;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign push = sample_event && (!fifo_full || pop);
  assign drop = sample_event && !push;

  assign frame_last = (cfg_frame_len_i != 16'd0) &&
                      (frame_cnt == cfg_frame_len_i - 16'd1);

  // FIFO storage; no reset needed since reads are gated by the empty flag
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= sample_word;
      mem_last[wr_ptr[AW-1:0]] <= frame_last;
    end
  end

  // FIFO pointers advance on accepted pushes and on stream handshakes
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Frame position counts accepted samples only; disabling starts a fresh frame
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      frame_cnt <= '0;
    end else if (!ctrl_en_i) begin
      frame_cnt <= '0;
    end else if (push) begin
      frame_cnt <= frame_last ? 16'd0 : frame_cnt + 16'd1;
    end
  end

  // Sticky overflow where a new drop outranks a same-cycle clear
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
    end else if (clr_overflow_i) begin
      overflow_o <= 1'b0;
    end
  end

  // Registered enable status
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      active_o <= 1'b0;
    end else begin
      active_o <= ctrl_en_i;
    end
  end

  assign wfg_axis_tvalid_o = !fifo_empty;
  assign wfg_axis_tdata_o  = fifo_empty ? '0 : mem_data[rd_ptr[AW-1:0]];
  assign wfg_axis_tlast_o  = fifo_empty ? 1'b0 : mem_last[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_wfg_record_pat.sv
// tb/tb_wfg_record_pat.sv - randomized self-checking bench for wfg_record_pat
module tb_wfg_record_pat;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  sub;
  logic [31:0] mask;
  logic [15:0] flen;
  logic        clr;
  logic        sync;
  logic [7:0]  cnt;
  logic [31:0] din;
  logic        tready;
  logic        tvalid;
  logic        tlast;
  logic [31:0] tdata;
  logic        ovf;
  logic        act;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       mq[$];
  logic [31:0] m_s1, m_s2;
  int          m_fpos;
  logic        m_ovf, m_act;

  always #5 clk = ~clk;

  wfg_record_pat #(
    .CHANNELS(32), .AXIS_DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .ctrl_en_i(en), .cfg_subcycle_i(sub),
    .cfg_mask_i(mask), .cfg_frame_len_i(flen), .clr_overflow_i(clr),
    .wfg_pat_sync_i(sync), .wfg_pat_subcycle_cnt_i(cnt), .pat_din_i(din),
    .wfg_axis_tready_i(tready), .wfg_axis_tvalid_o(tvalid),
    .wfg_axis_tlast_o(tlast), .wfg_axis_tdata_o(tdata),
    .overflow_o(ovf), .active_o(act)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_s1 = '0; m_s2 = '0; m_fpos = 0; m_ovf = 1'b0; m_act = 1'b0;
  endtask

  // Called at a negedge with inputs already set: compare, advance model, move to next negedge
  task automatic tick();
    logic        ev, hv, pop, acc, lst;
    logic [31:0] hd;
    logic        hl;
    hv = (mq.size() != 0);
    hd = hv ? mq[0].d : 32'd0;
    hl = hv ? mq[0].l : 1'b0;
    check_val("tvalid", {63'd0, tvalid}, {63'd0, hv});
    check_val("tdata", {32'd0, tdata}, {32'd0, hd});
    check_val("tlast", {63'd0, tlast}, {63'd0, hl});
    check_val("overflow", {63'd0, ovf}, {63'd0, m_ovf});
    check_val("active", {63'd0, act}, {63'd0, m_act});
    ev  = en && sync && (cnt == sub);
    pop = hv && tready;
    acc = ev && ((mq.size() < DEPTH) || pop);
    if (pop) void'(mq.pop_front());
    if (acc) begin
      lst = (flen != 0) && (((m_fpos + 1) % int'(flen)) == 0);
      mq.push_back('{m_s2 & mask, lst});
      m_fpos++;
    end
    if (!en) m_fpos = 0;
    if (ev && !acc) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_act = en;
    m_s2 = m_s1;
    m_s1 = din;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sample_at(input logic [7:0] c);
    sync = 1'b1; cnt = c;
    tick();
    sync = 1'b0; cnt = 8'd0;
  endtask

  initial begin
    rst = 1'b1; en = 0; sub = 0; mask = 0; flen = 0; clr = 0;
    sync = 0; cnt = 0; din = 0; tready = 0;
    model_clear();
    repeat (3) @(negedge clk);
    check_val("rst_tvalid", {63'd0, tvalid}, 64'd0);
    check_val("rst_tdata", {32'd0, tdata}, 64'd0);
    rst = 1'b0;
    tick();

    // Basic capture
    en = 1; mask = 32'hFFFF_FFFF; sub = 8'd3; din = 32'hA5A5_0F0F;
    repeat (3) tick();
    sample_at(8'd3);
    check_val("basic_valid", {63'd0, tvalid}, 64'd1);
    check_val("basic_data", {32'd0, tdata}, 64'hA5A5_0F0F);
    tready = 1;
    tick();
    sample_at(8'd2);
    check_val("wrong_cnt_novalid", {63'd0, tvalid}, 64'd0);
    tick();

    // Mask
    tready = 0; mask = 32'h0000_FFFF; din = 32'hDEAD_BEEF;
    repeat (2) tick();
    sample_at(8'd3);
    check_val("mask_data", {32'd0, tdata}, 64'h0000_BEEF);
    tready = 1;
    repeat (2) tick();

    // Framing
    en = 0; flen = 16'd3; mask = 32'hFFFF_FFFF;
    tick();
    en = 1;
    for (int i = 0; i < 7; i++) begin
      din = 32'h100 + i;
      sample_at(8'd3);
    end
    repeat (3) tick();
    en = 0; tick(); en = 1;
    for (int i = 0; i < 3; i++) sample_at(8'd3);
    repeat (3) tick();

    // Backpressure and overflow
    en = 0; flen = 16'd0; tick(); en = 1;
    tready = 0;
    for (int i = 0; i < 6; i++) begin
      din = 32'h200 + i;
      sample_at(8'd3);
    end
    check_val("bp_overflow", {63'd0, ovf}, 64'd1);
    repeat (2) tick();
    tready = 1;
    repeat (5) tick();
    clr = 1; tick(); clr = 0;
    check_val("ovf_cleared", {63'd0, ovf}, 64'd0);

    // Full with simultaneous pop
    tready = 0;
    for (int i = 0; i < DEPTH; i++) sample_at(8'd3);
    tready = 1;
    sample_at(8'd3);
    check_val("full_pop_no_ovf", {63'd0, ovf}, 64'd0);
    repeat (6) tick();

    // Reset mid-stream
    tready = 0;
    for (int i = 0; i < 3; i++) sample_at(8'd3);
    tick();
    rst = 1'b1;
    #1;
    check_val("rst_mid_tvalid", {63'd0, tvalid}, 64'd0);
    model_clear();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    tready = 1;
    repeat (4) tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        en = 0;
        sub = 8'($urandom_range(0, 3));
        flen = 16'($urandom_range(0, 4));
        mask = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
      end else begin
        en = 1;
      end
      sync = $urandom_range(0, 1) == 1;
      cnt = 8'($urandom_range(0, 3));
      din = $urandom;
      tready = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 19) == 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
